// File: rtl/ext_mem_mc.sv
// Multi-channel external memory model: round-robin valid/ready requests, single-beat writes,
// incrementing read bursts and an RD_LAT-stage read pipeline. EXTMEM_PRELOAD_EN enables zero-fill.
module ext_mem_mc #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned N_CH       = 3,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned INPUT_BASE = 4194304
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_valid,
    output logic [N_CH-1:0]          req_ready,
    input  logic [N_CH-1:0]          req_we,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*LEN_W-1:0]    req_len,
    input  logic [N_CH*DATA_W-1:0]   req_wdata,
    output logic [N_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_last,
    output logic                     busy
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StIdle, StRdBurst} state_e;

    state_e            state_q;
    logic [CH_W-1:0]   rr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CH_W-1:0]   ch_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              vld_q   [RD_LAT];
    logic [CH_W-1:0]   pch_q   [RD_LAT];
    logic              plast_q [RD_LAT];
    logic [DATA_W-1:0] data_q  [RD_LAT];

    logic              gnt_found;
    logic [CH_W-1:0]   gnt;
    logic [31:0]       idx;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [DATA_W-1:0] sel_wdata;
    logic              wr_en;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic [CH_W-1:0]   issue_ch;
    logic              issue_last;

`ifdef EXTMEM_PRELOAD_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
`endif

    // First asserted request at or after the round-robin pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (32'(rr_q) + 32'(i)) % N_CH;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt       = CH_W'(idx);
            end
        end
    end

    always_comb begin
        accept    = gnt_found && (state_q == StIdle) && !rst;
        req_ready = accept ? (N_CH'(1) << gnt) : '0;
        sel_we    = req_we[gnt];
        sel_addr  = req_addr[gnt*ADDR_W +: ADDR_W];
        sel_len   = req_len[gnt*LEN_W +: LEN_W];
        sel_wdata = req_wdata[gnt*DATA_W +: DATA_W];
        wr_en     = accept && sel_we;
    end

    always_comb begin
        issue      = 1'b0;
        issue_addr = addr_q;
        issue_ch   = ch_q;
        issue_last = (cnt_q == LEN_W'(1));
        if (state_q == StRdBurst) begin
            issue = 1'b1;
        end else if (accept && !sel_we) begin
            issue      = 1'b1;
            issue_addr = sel_addr;
            issue_ch   = gnt;
            issue_last = (sel_len == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            ch_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        rr_q <= (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
                        if (!sel_we && sel_len != '0) begin
                            state_q <= StRdBurst;
                            cnt_q   <= sel_len;
                            addr_q  <= sel_addr + 1'b1;
                            ch_q    <= gnt;
                        end
                    end
                end
                StRdBurst: begin
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Control half of the read pipeline; cleared by reset so in-flight beats vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]   <= 1'b0;
                pch_q[i]   <= '0;
                plast_q[i] <= 1'b0;
            end
        end else begin
            vld_q[0]   <= issue;
            pch_q[0]   <= issue_ch;
            plast_q[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                pch_q[i]   <= pch_q[i-1];
                plast_q[i] <= plast_q[i-1];
            end
        end
    end

    // Array and data half of the pipeline carry no reset so the array can map to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[sel_addr] <= sel_wdata;
        if (issue) data_q[0] <= mem[issue_addr];
        for (int i = 1; i < RD_LAT; i++) data_q[i] <= data_q[i-1];
    end

    always_comb begin
        rsp_valid = vld_q[RD_LAT-1] ? (N_CH'(1) << pch_q[RD_LAT-1]) : '0;
        rsp_last  = vld_q[RD_LAT-1] && plast_q[RD_LAT-1];
        rsp_data  = vld_q[RD_LAT-1] ? data_q[RD_LAT-1] : '0;
        busy      = (state_q != StIdle);
        for (int i = 0; i < RD_LAT; i++) busy = busy | vld_q[i];
    end

endmodule
